// File: rtl/downmix_sweep_ctrl_pkg.sv
// downmix_pkg: shared sweep state encoding, default tuning words and accumulator width helper.
package downmix_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RETUNE,
      S_SETTLE,
      S_INTEG,
      S_EVAL,
      S_DONE
   } sweep_state_t;

   localparam logic [15:0] DEF_F_START = 16'h0800;
   localparam logic [15:0] DEF_F_STEP  = 16'h0040;

   // One sign bit of headroom for |I|+|Q| plus log2(DWELL) bits of growth.
   function automatic int aw_width(input int nout, input int dwell);
      return nout + 1 + $clog2(dwell);
   endfunction

endpackage

// File: rtl/downmix_sweep_ctrl_iq_mag_acc.sv
// iq_mag_acc: saturating |I|+|Q| per sample, summed into a clearable accumulator.
module iq_mag_acc #(
   parameter int NOUT = 16,
   parameter int AW   = 22
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clr,
   input  logic                   i_tick,
   input  logic signed [NOUT-1:0] i_i,
   input  logic signed [NOUT-1:0] i_q,
   output logic        [AW-1:0]   o_acc
);

   // The most negative input has no positive twin, so it clamps to full scale.
   function automatic logic [NOUT-2:0] sat_abs(input logic signed [NOUT-1:0] x);
      return !x[NOUT-1] ? x[NOUT-2:0] :
             (x[NOUT-2:0] == '0) ? {(NOUT-1){1'b1}} : (NOUT-1)'(-x);
   endfunction

   logic [NOUT:0] w_mag;

   assign w_mag = (NOUT+1)'(sat_abs(i_i)) + (NOUT+1)'(sat_abs(i_q));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_acc <= '0;
      else if (i_clr)
         o_acc <= '0;
      else if (i_tick)
         o_acc <= o_acc + AW'(w_mag);
   end

endmodule

// File: rtl/downmix_sweep_ctrl.sv
// downmix_sweep_ctrl: steps the mixer NCO across a sweep, integrates |I|+|Q| per step
// and keeps the step with the largest energy.
module downmix_sweep_ctrl
   import downmix_pkg::*;
#(
   parameter int             NOUT    = 16,
   parameter int             NFW     = 16,
   parameter logic [NFW-1:0] F_START = NFW'(DEF_F_START),
   parameter logic [NFW-1:0] F_STEP  = NFW'(DEF_F_STEP),
   parameter int             N_STEPS = 16,
   parameter int             SETTLE  = 8,
   parameter int             DWELL   = 32
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_en,
   input  logic                                 i_start,
   input  logic                                 i_sample_tick,
   input  logic signed [NOUT-1:0]               i_i_in,
   input  logic signed [NOUT-1:0]               i_q_in,
   output logic        [NFW-1:0]                o_freq_word,
   output logic                                 o_mixer_clr,
   output logic                                 o_busy,
   output logic                                 o_sweep_done,
   output logic        [$clog2(N_STEPS)-1:0]    o_peak_idx,
   output logic        [NFW-1:0]                o_peak_freq,
   output logic        [aw_width(NOUT,DWELL)-1:0] o_peak_energy
);

   localparam int AW = aw_width(NOUT, DWELL);
   localparam int SW = $clog2(N_STEPS);
   localparam int CW = $clog2(SETTLE > DWELL ? SETTLE : DWELL) + 1;
   localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE - 1);
   localparam logic [CW-1:0] DW_LAST   = CW'(DWELL - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(N_STEPS - 1);

   sweep_state_t  r_state;
   logic [SW-1:0] r_step;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] w_acc;
   logic          w_acc_clr;
   logic          w_acc_tick;

   assign w_acc_clr  = r_state == S_RETUNE;
   assign w_acc_tick = i_sample_tick && r_state == S_INTEG;

   iq_mag_acc #(
      .NOUT(NOUT),
      .AW  (AW)
   ) u_acc (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_clr  (w_acc_clr),
      .i_tick (w_acc_tick),
      .i_i    (i_i_in),
      .i_q    (i_q_in),
      .o_acc  (w_acc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_step        <= '0;
         r_cnt         <= '0;
         o_freq_word   <= F_START;
         o_mixer_clr   <= 1'b0;
         o_busy        <= 1'b0;
         o_sweep_done  <= 1'b0;
         o_peak_idx    <= '0;
         o_peak_freq   <= '0;
         o_peak_energy <= '0;
      end else if (!i_en) begin
         // Abort keeps the partial peak and the current tuning word.
         r_state      <= S_IDLE;
         o_busy       <= 1'b0;
         o_sweep_done <= 1'b0;
         o_mixer_clr  <= 1'b0;
      end else begin
         o_mixer_clr <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_state       <= S_RETUNE;
               r_step        <= '0;
               o_freq_word   <= F_START;
               o_mixer_clr   <= 1'b1;
               o_busy        <= 1'b1;
               o_sweep_done  <= 1'b0;
               o_peak_idx    <= '0;
               o_peak_freq   <= '0;
               o_peak_energy <= '0;
            end
            S_RETUNE: begin
               r_cnt   <= '0;
               r_state <= S_SETTLE;
            end
            S_SETTLE: if (i_sample_tick) begin
               r_cnt   <= (r_cnt == SET_LAST) ? '0 : r_cnt + CW'(1);
               r_state <= (r_cnt == SET_LAST) ? S_INTEG : S_SETTLE;
            end
            S_INTEG: if (i_sample_tick) begin
               r_cnt   <= r_cnt + CW'(1);
               r_state <= (r_cnt == DW_LAST) ? S_EVAL : S_INTEG;
            end
            S_EVAL: begin
               // Strict compare: on equal energy the earlier step is kept.
               if (r_step == '0 || w_acc > o_peak_energy) begin
                  o_peak_idx    <= r_step;
                  o_peak_freq   <= o_freq_word;
                  o_peak_energy <= w_acc;
               end
               if (r_step == STEP_LAST)
                  r_state <= S_DONE;
               else begin
                  r_step      <= r_step + SW'(1);
                  o_freq_word <= o_freq_word + F_STEP;
                  o_mixer_clr <= 1'b1;
                  r_state     <= S_RETUNE;
               end
            end
            S_DONE: begin
               o_sweep_done <= 1'b1;
               o_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_downmix_sweep_ctrl.sv
// tb_downmix_sweep_ctrl: table-driven sweeps with a retune scoreboard, plus abort and reset sequences.
module tb_downmix_sweep_ctrl;

   logic               i_clk;
   logic               i_rst_n;
   logic               i_en;
   logic               i_start;
   logic               i_sample_tick;
   logic signed [15:0] i_i_in;
   logic signed [15:0] i_q_in;
   logic [15:0]        o_freq_word;
   logic               o_mixer_clr;
   logic               o_busy;
   logic               o_sweep_done;
   logic [3:0]         o_peak_idx;
   logic [15:0]        o_peak_freq;
   logic [21:0]        o_peak_energy;

   downmix_sweep_ctrl dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en),
      .i_start      (i_start),
      .i_sample_tick(i_sample_tick),
      .i_i_in       (i_i_in),
      .i_q_in       (i_q_in),
      .o_freq_word  (o_freq_word),
      .o_mixer_clr  (o_mixer_clr),
      .o_busy       (o_busy),
      .o_sweep_done (o_sweep_done),
      .o_peak_idx   (o_peak_idx),
      .o_peak_freq  (o_peak_freq),
      .o_peak_energy(o_peak_energy)
   );

   typedef struct {
      logic signed [15:0] ni;
      logic signed [15:0] nq;
      int                 pk;
      logic signed [15:0] pi;
      logic signed [15:0] pq;
      int                 gap;
      int                 inj;
      logic [3:0]         e_idx;
      logic [15:0]        e_freq;
      logic [21:0]        e_energy;
   } vec_t;

   typedef struct {
      int          step;
      logic [15:0] freq;
   } exp_t;

   vec_t               tv[5];
   exp_t               q[$];
   int                 checks = 0;
   int                 errors = 0;
   int                 gap = 0;
   int                 tcnt = 0;
   int                 clr_cnt = 0;
   int                 pk_step = -1;
   logic signed [15:0] norm_i, norm_q, pk_i, pk_q;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock: sample outputs at negedge, retire a retune from the scoreboard, drive inputs.
   task automatic cyc(input logic st);
      exp_t e;
      @(negedge i_clk);
      if (o_mixer_clr) begin
         clr_cnt++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mixer_clr_unexpected: got pulse at freq 0x%0h, expected none", o_freq_word);
         end else begin
            e = q.pop_front();
            chk("freq_step", 64'(o_freq_word), 64'(e.freq));
            i_i_in = (e.step == pk_step) ? pk_i : norm_i;
            i_q_in = (e.step == pk_step) ? pk_q : norm_q;
         end
      end
      i_start       = st;
      tcnt++;
      i_sample_tick = (gap != 0) && (tcnt % gap == 0);
   endtask

   task automatic push_all();
      for (int s = 0; s < 16; s++) q.push_back('{s, 16'h0800 + 16'(s * 64)});
   endtask

   task automatic run_sweep(input vec_t v);
      int n;
      int base;
      norm_i  = v.ni;
      norm_q  = v.nq;
      pk_step = v.pk;
      pk_i    = v.pi;
      pk_q    = v.pq;
      gap     = v.gap;
      base    = clr_cnt;
      push_all();
      cyc(1'b1);
      cyc(1'b0);
      chk("start_busy", 64'(o_busy), 64'd1);
      chk("start_done_clr", 64'(o_sweep_done), 64'd0);
      n = 0;
      while (!o_sweep_done && n < 8000) begin
         cyc(v.inj != 0 && n == v.inj);
         n++;
      end
      chk("sweep_done", 64'(o_sweep_done), 64'd1);
      chk("retune_count", 64'(clr_cnt - base), 64'd16);
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("done_busy", 64'(o_busy), 64'd0);
      chk("peak_idx", 64'(o_peak_idx), 64'(v.e_idx));
      chk("peak_freq", 64'(o_peak_freq), 64'(v.e_freq));
      chk("peak_energy", 64'(o_peak_energy), 64'(v.e_energy));
      q.delete();
      repeat (3) cyc(1'b0);
   endtask

   initial begin
      int n;
      i_rst_n = 1'b0;
      i_en = 1'b0;
      i_start = 1'b0;
      i_sample_tick = 1'b0;
      i_i_in = '0;
      i_q_in = '0;
      norm_i = 16'sd100;
      norm_q = -16'sd50;
      pk_i = '0;
      pk_q = '0;
      tv[0] = '{16'sd100, -16'sd50, -1, 16'sd0, 16'sd0, 3, 0, 4'd0, 16'h0800, 22'd4800};
      tv[1] = '{16'sd100, -16'sd50, 5, 16'sd300, 16'sd0, 2, 0, 4'd5, 16'h0940, 22'd9600};
      tv[2] = '{16'sh8000, 16'sh8000, -1, 16'sd0, 16'sd0, 1, 0, 4'd0, 16'h0800, 22'd2097088};
      tv[3] = '{16'sd100, -16'sd50, 15, -16'sd200, -16'sd200, 3, 0, 4'd15, 16'h0BC0, 22'd12800};
      tv[4] = '{16'sd100, -16'sd50, -1, 16'sd0, 16'sd0, 1, 300, 4'd0, 16'h0800, 22'd4800};

      repeat (3) cyc(1'b0);
      chk("rst_freq", 64'(o_freq_word), 64'h0800);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_sweep_done), 64'd0);
      chk("rst_clr", 64'(o_mixer_clr), 64'd0);
      chk("rst_energy", 64'(o_peak_energy), 64'd0);
      i_rst_n = 1'b1;
      i_en = 1'b1;
      gap = 3;
      repeat (20) cyc(1'b0);
      chk("idle_busy", 64'(o_busy), 64'd0);

      i_en = 1'b0;
      cyc(1'b1);
      repeat (5) cyc(1'b0);
      chk("start_en_low", 64'(o_busy), 64'd0);
      i_en = 1'b1;
      cyc(1'b0);

      for (int k = 0; k < 5; k++) run_sweep(tv[k]);

      norm_i = 16'sd100;
      norm_q = -16'sd50;
      pk_step = -1;
      gap = 3;
      push_all();
      cyc(1'b1);
      n = 0;
      while (o_freq_word !== 16'h09C0 && n < 4000) begin
         cyc(1'b0);
         n++;
      end
      chk("abort_reach_step7", 64'(o_freq_word), 64'h09C0);
      repeat (40) cyc(1'b0);
      chk("abort_busy_before", 64'(o_busy), 64'd1);
      i_en = 1'b0;
      cyc(1'b0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_done", 64'(o_sweep_done), 64'd0);
      chk("abort_freq_hold", 64'(o_freq_word), 64'h09C0);
      chk("abort_peak_energy", 64'(o_peak_energy), 64'd4800);
      q.delete();
      i_en = 1'b1;
      cyc(1'b0);
      run_sweep(tv[0]);

      push_all();
      cyc(1'b1);
      n = 0;
      while (o_freq_word !== 16'h0880 && n < 4000) begin
         cyc(1'b0);
         n++;
      end
      repeat (50) cyc(1'b0);
      chk("midinteg_busy", 64'(o_busy), 64'd1);
      i_rst_n = 1'b0;
      cyc(1'b0);
      chk("rst2_freq", 64'(o_freq_word), 64'h0800);
      chk("rst2_busy", 64'(o_busy), 64'd0);
      chk("rst2_done", 64'(o_sweep_done), 64'd0);
      chk("rst2_clr", 64'(o_mixer_clr), 64'd0);
      chk("rst2_idx", 64'(o_peak_idx), 64'd0);
      chk("rst2_pfreq", 64'(o_peak_freq), 64'd0);
      chk("rst2_energy", 64'(o_peak_energy), 64'd0);
      q.delete();
      i_rst_n = 1'b1;
      repeat (60) cyc(1'b0);
      chk("rst2_idle_busy", 64'(o_busy), 64'd0);
      chk("rst2_idle_freq", 64'(o_freq_word), 64'h0800);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
